lwst_issue_ctrl: RTL and testbench

- Load/store issue controller between the CPU MEM stage and the memory-mapped-to-stream arbiter.
- Converts one-cycle CPU load/store requests into arbiter request beats (writedata/addr/read_req/write_req/lwst_start).
- Tracks outstanding loads and stores and stalls the pipeline when full.
- Returns load data in order to register-file writeback, tagged with the destination register.

---
 rtl/lwst_issue_ctrl_pkg.sv | 14 +
 rtl/lwst_issue_ctrl_fifo.sv | 49 ++++
 rtl/lwst_issue_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_lwst_issue_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lwst_issue_ctrl_pkg.sv
// Shared widths and controller state encoding for the load/store issue controller.
package lwst_issue_ctrl_pkg;

    localparam int WORD_BITS     = 32;
    localparam int MEM_ADDR_BITS = 16;
    localparam int REG_ADDR_BITS = 5;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/lwst_issue_ctrl_fifo.sv
// Small synchronous FIFO holding destination-register tags of loads in flight.
module lwst_issue_ctrl_fifo #(
    parameter int p_st_bits    = 5,
    parameter int p_depth      = 8,
    parameter int p_depth_log2 = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_clear,
    input  logic                 i_push,
    input  logic [p_st_bits-1:0] i_data,
    input  logic                 i_pop,
    output logic [p_st_bits-1:0] o_data,
    output logic                 o_empty
);

    logic [p_st_bits-1:0]    mem_q [p_depth];
    logic [p_depth_log2-1:0] wr_ptr_q, rd_ptr_q;
    logic [p_depth_log2:0]   count_q;
    logic                    do_push, do_pop, full;

    assign o_empty = (count_q == '0);
    assign full    = (count_q == (p_depth_log2+1)'(p_depth));
    assign do_push = i_push && !full;
    assign do_pop  = i_pop && !o_empty;
    assign o_data  = mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (i_clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + p_depth_log2'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + p_depth_log2'(1);
            count_q <= count_q + (p_depth_log2+1)'(do_push) - (p_depth_log2+1)'(do_pop);
        end
    end

    // Storage needs no reset; the pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= i_data;
    end

endmodule

// File: rtl/lwst_issue_ctrl.sv
// Load/store issue controller between MEM stage and arbiter; in-order load writeback.
// Define LWST_TIMEOUT_EN to add the o_timeout watchdog.
module lwst_issue_ctrl
    import lwst_issue_ctrl_pkg::*;
#(
    parameter int p_st_bits              = WORD_BITS,
    parameter int p_addr_bits            = MEM_ADDR_BITS,
    parameter int p_reg_addr_bits        = REG_ADDR_BITS,
    parameter int p_max_outstanding      = 8,
    parameter int p_max_outstanding_log2 = 3
`ifdef LWST_TIMEOUT_EN
    ,
    parameter int p_timeout_cycles       = 1024
`endif
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_cpu_req,
    input  logic                       i_cpu_we,
    input  logic [p_addr_bits-1:0]     i_cpu_addr,
    input  logic [p_st_bits-1:0]       i_cpu_wdata,
    input  logic [p_reg_addr_bits-1:0] i_cpu_rd,
    input  logic                       i_flush,
    output logic                       o_cpu_stall,
    output logic                       o_flush_done,
    output logic [p_st_bits-1:0]       o_writedata,
    output logic [p_addr_bits-1:0]     o_addr,
    output logic                       o_read_req,
    output logic                       o_write_req,
    output logic                       o_lwst_start,
    input  logic [p_st_bits-1:0]       i_readdata,
    input  logic                       i_valid,
    input  logic                       i_write_mem_complete,
    output logic                       o_wb_en,
    output logic [p_reg_addr_bits-1:0] o_wb_addr,
    output logic [p_st_bits-1:0]       o_wb_data,
    output logic                       o_busy,
`ifdef LWST_TIMEOUT_EN
    output logic                       o_timeout,
`endif
    output logic                       o_err
);

    localparam int CW = p_max_outstanding_log2 + 1;

    state_e                     state_q, state_d;
    logic [CW-1:0]              rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
    logic                       err_q, err_d, flush_done_q, flush_done_d;
    logic                       start_q, read_req_q, write_req_q, wb_en_q;
    logic [p_addr_bits-1:0]     addr_q;
    logic [p_st_bits-1:0]       wdata_q, wb_data_q;
    logic [p_reg_addr_bits-1:0] wb_addr_q, fifo_head;
    logic                       accept, ld_acc, st_acc, rd_dec, wr_dec, cnt_zero;
    logic                       fifo_empty, fifo_clear, wb_fire;

    assign o_cpu_stall = (({1'b0, rd_cnt_q} + {1'b0, wr_cnt_q}) == (CW+1)'(p_max_outstanding))
                         || (state_q == S_DRAIN) || i_flush;
    assign accept  = i_cpu_req && !o_cpu_stall;
    assign ld_acc  = accept && !i_cpu_we;
    assign st_acc  = accept && i_cpu_we;
    assign rd_dec  = i_valid && (rd_cnt_q != '0);
    assign wr_dec  = i_write_mem_complete && (wr_cnt_q != '0);
    assign wb_fire = i_valid && !fifo_empty;
    assign err_d   = err_q || (i_valid && (rd_cnt_q == '0))
                     || (i_write_mem_complete && (wr_cnt_q == '0));

    assign o_busy       = (state_q != S_IDLE);
    assign o_err        = err_q;
    assign o_flush_done = flush_done_q;
    assign o_lwst_start = start_q;
    assign o_read_req   = read_req_q;
    assign o_write_req  = write_req_q;
    assign o_addr       = addr_q;
    assign o_writedata  = wdata_q;
    assign o_wb_en      = wb_en_q;
    assign o_wb_addr    = wb_addr_q;
    assign o_wb_data    = wb_data_q;

`ifdef LWST_TIMEOUT_EN
    localparam int WW = $clog2(p_timeout_cycles) + 1;
    logic [WW-1:0] wdog_q, wdog_d;
    logic          timeout_q, timeout_hit, any_done;

    assign any_done    = i_valid || i_write_mem_complete;
    assign timeout_hit = o_busy && !any_done && (wdog_q == WW'(p_timeout_cycles - 1));
    assign wdog_d      = (!o_busy || any_done || timeout_hit) ? '0 : wdog_q + WW'(1);
    assign o_timeout   = timeout_q;
    assign fifo_clear  = timeout_hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            wdog_q    <= wdog_d;
            timeout_q <= timeout_q || timeout_hit;
        end
    end
`else
    assign fifo_clear = 1'b0;
`endif

    // Draining wins over everything; counts are judged on their next values so
    // the return to idle coincides with the last completion.
    always_comb begin
        rd_cnt_d     = rd_cnt_q + CW'(ld_acc) - CW'(rd_dec);
        wr_cnt_d     = wr_cnt_q + CW'(st_acc) - CW'(wr_dec);
        cnt_zero     = (rd_cnt_d == '0) && (wr_cnt_d == '0);
        state_d      = state_q;
        flush_done_d = 1'b0;
        if ((state_q == S_DRAIN) || i_flush) begin
            if (cnt_zero) begin
                state_d      = S_IDLE;
                flush_done_d = 1'b1;
            end else begin
                state_d = S_DRAIN;
            end
        end else if (accept) begin
            state_d = S_BUSY;
        end else if (cnt_zero) begin
            state_d = S_IDLE;
        end
`ifdef LWST_TIMEOUT_EN
        if (timeout_hit) begin
            state_d  = S_IDLE;
            rd_cnt_d = '0;
            wr_cnt_d = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            rd_cnt_q     <= '0;
            wr_cnt_q     <= '0;
            err_q        <= 1'b0;
            flush_done_q <= 1'b0;
            start_q      <= 1'b0;
            read_req_q   <= 1'b0;
            write_req_q  <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wb_en_q      <= 1'b0;
            wb_addr_q    <= '0;
            wb_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            rd_cnt_q     <= rd_cnt_d;
            wr_cnt_q     <= wr_cnt_d;
            err_q        <= err_d;
            flush_done_q <= flush_done_d;
            start_q      <= accept;
            wb_en_q      <= wb_fire;
            if (accept) begin
                addr_q      <= i_cpu_addr;
                wdata_q     <= i_cpu_wdata;
                read_req_q  <= !i_cpu_we;
                write_req_q <= i_cpu_we;
            end
            if (wb_fire) begin
                wb_addr_q <= fifo_head;
                wb_data_q <= i_readdata;
            end
        end
    end

    lwst_issue_ctrl_fifo #(
        .p_st_bits    (p_reg_addr_bits),
        .p_depth      (p_max_outstanding),
        .p_depth_log2 (p_max_outstanding_log2)
    ) u_tag_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_clear (fifo_clear),
        .i_push  (ld_acc),
        .i_data  (i_cpu_rd),
        .i_pop   (i_valid),
        .o_data  (fifo_head),
        .o_empty (fifo_empty)
    );

endmodule

// File: tb/tb_lwst_issue_ctrl.sv
// Randomized bench for lwst_issue_ctrl against a queue-based reference model.
module tb_lwst_issue_ctrl;
    import lwst_issue_ctrl_pkg::*;

    localparam int AW   = MEM_ADDR_BITS;
    localparam int DW   = WORD_BITS;
    localparam int RW   = REG_ADDR_BITS;
    localparam int MAXO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpuReq, cpuWe, flush, valid, wComp;
    logic [AW-1:0] cpuAddr;
    logic [DW-1:0] cpuWdata, readData;
    logic [RW-1:0] cpuRd;
    logic          stall, flushDone, readReq, writeReq, lwstStart, wbEn, busy, err;
    logic [DW-1:0] writeData, wbData;
    logic [AW-1:0] addr;
    logic [RW-1:0] wbAddr;
`ifdef LWST_TIMEOUT_EN
    logic          timeout;
`endif

    always #5 clk = ~clk;

    lwst_issue_ctrl dut (
        .clk                  (clk),
        .rst                  (rst),
        .i_cpu_req            (cpuReq),
        .i_cpu_we             (cpuWe),
        .i_cpu_addr           (cpuAddr),
        .i_cpu_wdata          (cpuWdata),
        .i_cpu_rd             (cpuRd),
        .i_flush              (flush),
        .o_cpu_stall          (stall),
        .o_flush_done         (flushDone),
        .o_writedata          (writeData),
        .o_addr               (addr),
        .o_read_req           (readReq),
        .o_write_req          (writeReq),
        .o_lwst_start         (lwstStart),
        .i_readdata           (readData),
        .i_valid              (valid),
        .i_write_mem_complete (wComp),
        .o_wb_en              (wbEn),
        .o_wb_addr            (wbAddr),
        .o_wb_data            (wbData),
        .o_busy               (busy),
`ifdef LWST_TIMEOUT_EN
        .o_timeout            (timeout),
`endif
        .o_err                (err)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: pending load tags in a queue, stores as a plain count.
    int            tagQ[$];
    int            wrOut;
    bit            draining, active, errM;
    logic          expStart, expRead, expWrite, expWbEn, expFlushDone;
    logic [AW-1:0] expAddr;
    logic [DW-1:0] expWdata, expWbData;
    logic [RW-1:0] expWbAddr;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        tagQ.delete();
        wrOut = 0; draining = 0; active = 0; errM = 0;
        expStart = 0; expRead = 0; expWrite = 0; expWbEn = 0; expFlushDone = 0;
        expAddr = '0; expWdata = '0; expWbData = '0; expWbAddr = '0;
    endtask

    task automatic checkAll();
        checkOutput("lwst_start", lwstStart, expStart);
        checkOutput("read_req", readReq, expRead);
        checkOutput("write_req", writeReq, expWrite);
        checkOutput("addr", addr, expAddr);
        checkOutput("writedata", writeData, expWdata);
        checkOutput("wb_en", wbEn, expWbEn);
        checkOutput("wb_addr", wbAddr, expWbAddr);
        checkOutput("wb_data", wbData, expWbData);
        checkOutput("flush_done", flushDone, expFlushDone);
        checkOutput("busy", busy, active || draining);
        checkOutput("err", err, errM);
    endtask

    task automatic applyStimulus(input bit req, input bit we, input logic [AW-1:0] a,
                                 input logic [DW-1:0] wd, input logic [RW-1:0] rd,
                                 input bit fl, input bit vld, input logic [DW-1:0] rdata,
                                 input bit wc);
        bit stallM, acc;
        @(negedge clk);
        cpuReq = req; cpuWe = we; cpuAddr = a; cpuWdata = wd; cpuRd = rd;
        flush = fl; valid = vld; readData = rdata; wComp = wc;
        #1;
        stallM = ((tagQ.size() + wrOut) == MAXO) || draining || fl;
        checkOutput("stall", stall, stallM);
        acc = req && !stallM;
        expStart = acc;
        if (acc) begin
            expAddr = a; expWdata = wd; expRead = !we; expWrite = we;
        end
        expWbEn = 0;
        if (vld) begin
            if (tagQ.size() > 0) begin
                expWbEn   = 1;
                expWbAddr = RW'(tagQ.pop_front());
                expWbData = rdata;
            end else begin
                errM = 1;
            end
        end
        if (wc) begin
            if (wrOut > 0) wrOut--;
            else errM = 1;
        end
        if (acc && !we) tagQ.push_back(int'(rd));
        if (acc && we) wrOut++;
        expFlushDone = 0;
        if (draining || fl) begin
            if ((tagQ.size() + wrOut) == 0) begin
                draining = 0; active = 0; expFlushDone = 1;
            end else begin
                draining = 1;
            end
        end else if (acc) begin
            active = 1;
        end else if ((tagQ.size() + wrOut) == 0) begin
            active = 0;
        end
        @(posedge clk);
        #1;
        checkAll();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, '0, '0, '0, 0, 0, '0, 0);
    endtask

    task automatic resetDut();
        #2;
        cpuReq = 0; cpuWe = 0; cpuAddr = '0; cpuWdata = '0; cpuRd = '0;
        flush = 0; valid = 0; readData = '0; wComp = 0;
        rst = 1'b0;
        #1;
        modelReset();
        checkAll();
        checkOutput("rst_stall", stall, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int guard;
        cpuReq = 0; cpuWe = 0; cpuAddr = '0; cpuWdata = '0; cpuRd = '0;
        flush = 0; valid = 0; readData = '0; wComp = 0;
        rst = 1'b0;
        resetDut();

        // Single load with a three-cycle memory latency
        applyStimulus(1, 0, 'h10, '0, 5, 0, 0, '0, 0);
        checkOutput("single_rdreq", readReq, 1);
        checkOutput("single_addr", addr, 'h10);
        idle(2);
        applyStimulus(0, 0, '0, '0, '0, 0, 1, 'hDEADBEEF, 0);
        checkOutput("single_wb_addr", wbAddr, 5);
        checkOutput("single_wb_data", wbData, 'hDEADBEEF);
        idle(1);
        checkOutput("single_busy_fall", busy, 0);

        // Eight loads fill the window, the ninth is held off
        for (int i = 1; i <= 8; i++) applyStimulus(1, 0, AW'(16'h40 + i), '0, RW'(i), 0, 0, '0, 0);
        applyStimulus(1, 0, 'h99, '0, 9, 0, 0, '0, 0);
        checkOutput("full_stall", stall, 1);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 0, '0, '0, '0, 0, 1, DW'(32'h100 + i), 0);
            checkOutput("full_wb_addr", wbAddr, i + 1);
            checkOutput("full_wb_data", wbData, 32'h100 + i);
        end

        // Store then load to the same address
        applyStimulus(1, 1, 'h20, 'h55, '0, 0, 0, '0, 0);
        checkOutput("mixed_wrreq", writeReq, 1);
        checkOutput("mixed_wdata", writeData, 'h55);
        applyStimulus(1, 0, 'h20, '0, 3, 0, 0, '0, 0);
        checkOutput("mixed_rdreq", readReq, 1);
        applyStimulus(0, 0, '0, '0, '0, 0, 0, '0, 1);
        applyStimulus(0, 0, '0, '0, '0, 0, 1, 'h55, 0);
        checkOutput("mixed_wb_addr", wbAddr, 3);

        // Load accepted in the same cycle an earlier load returns
        applyStimulus(1, 0, 'h30, '0, 10, 0, 0, '0, 0);
        applyStimulus(1, 0, 'h34, '0, 11, 0, 1, 'hA, 0);
        checkOutput("simul_wb_addr", wbAddr, 10);
        applyStimulus(0, 0, '0, '0, '0, 0, 1, 'hB, 0);
        checkOutput("simul_wb_addr2", wbAddr, 11);

        // Drain three outstanding stores
        for (int i = 0; i < 3; i++) applyStimulus(1, 1, AW'(16'h80 + i), DW'(i), '0, 0, 0, '0, 0);
        applyStimulus(0, 0, '0, '0, '0, 1, 0, '0, 0);
        applyStimulus(1, 0, 'h90, '0, 1, 0, 0, '0, 0);
        checkOutput("drain_stall", stall, 1);
        applyStimulus(0, 0, '0, '0, '0, 0, 0, '0, 1);
        applyStimulus(0, 0, '0, '0, '0, 0, 0, '0, 1);
        checkOutput("drain_not_done", flushDone, 0);
        applyStimulus(0, 0, '0, '0, '0, 0, 0, '0, 1);
        checkOutput("drain_done", flushDone, 1);
        idle(1);
        checkOutput("drain_pulse_once", flushDone, 0);
        checkOutput("drain_idle", busy, 0);

        // Flush while idle
        applyStimulus(0, 0, '0, '0, '0, 1, 0, '0, 0);
        checkOutput("idle_flush_done", flushDone, 1);

        // Random traffic; responses only for work the model knows about
        for (int n = 0; n < 1500; n++) begin
            applyStimulus($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                          AW'($urandom), DW'($urandom), RW'($urandom),
                          $urandom_range(0, 31) == 0,
                          (tagQ.size() > 0) && ($urandom_range(0, 2) == 0), DW'($urandom),
                          (wrOut > 0) && ($urandom_range(0, 2) == 0));
        end
        guard = 0;
        while (((tagQ.size() + wrOut) > 0) && (guard < 100)) begin
            applyStimulus(0, 0, '0, '0, '0, 0, tagQ.size() > 0, DW'($urandom), wrOut > 0);
            guard++;
        end
        checkOutput("random_drained", guard < 100, 1);

        // Spurious response while idle
        applyStimulus(0, 0, '0, '0, '0, 0, 1, 'h1234, 0);
        checkOutput("spurious_err", err, 1);
        checkOutput("spurious_no_wb", wbEn, 0);

        // Asynchronous reset in the middle of traffic
        applyStimulus(1, 0, 'h44, '0, 7, 0, 0, '0, 0);
        applyStimulus(1, 1, 'h48, 'h99, '0, 0, 0, '0, 0);
        resetDut();
        for (int i = 0; i < 8; i++) applyStimulus(1, 0, AW'(i), '0, RW'(i), 0, 0, '0, 0);
        applyStimulus(1, 1, 'h50, 'h1, '0, 0, 0, '0, 0);
        for (int i = 0; i < 8; i++) applyStimulus(0, 0, '0, '0, '0, 0, 1, DW'(i * 3), 0);

`ifdef LWST_TIMEOUT_EN
        applyStimulus(1, 0, 'h60, '0, 2, 0, 0, '0, 0);
        @(negedge clk);
        cpuReq = 0;
        guard = 0;
        while (!timeout && (guard < 1100)) begin
            @(posedge clk);
            #1;
            guard++;
        end
        checkOutput("timeout_cycles", guard, 1024);
        checkOutput("timeout_stall", stall, 0);
        checkOutput("timeout_busy", busy, 0);
        resetDut();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
